// File: rtl/obi_axil_dram_bridge.sv
// OBI responder that turns each granted transfer into one AXI4-Lite read or write
// toward the DDR controller; addresses outside the window are answered locally with err.
module obi_axil_dram_bridge #(
    parameter logic [31:0] ADDR_BASE   = 32'h4000_0000,
    parameter logic [31:0] WINDOW_SIZE = 32'h1000_0000,
    parameter int          AXI_AW      = 32
) (
    input  logic              clk_gen,
    input  logic              rst_n,
    input  logic              obi_req_i,
    output logic              obi_gnt_o,
    input  logic [31:0]       obi_addr_i,
    input  logic              obi_we_i,
    input  logic [3:0]        obi_be_i,
    input  logic [31:0]       obi_wdata_i,
    output logic              obi_rvalid_o,
    output logic [31:0]       obi_rdata_o,
    output logic              obi_err_o,
    output logic              m_awvalid_o,
    input  logic              m_awready_i,
    output logic [AXI_AW-1:0] m_awaddr_o,
    output logic              m_wvalid_o,
    input  logic              m_wready_i,
    output logic [31:0]       m_wdata_o,
    output logic [3:0]        m_wstrb_o,
    input  logic              m_bvalid_i,
    output logic              m_bready_o,
    input  logic [1:0]        m_bresp_i,
    output logic              m_arvalid_o,
    input  logic              m_arready_i,
    output logic [AXI_AW-1:0] m_araddr_o,
    input  logic              m_rvalid_i,
    output logic              m_rready_o,
    input  logic [31:0]       m_rdata_i,
    input  logic [1:0]        m_rresp_i
);

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RESP} state_t;

    state_t              state_q, state_d;
    logic                aw_pend_q, aw_pend_d;
    logic                w_pend_q, w_pend_d;
    logic [AXI_AW-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [31:0]         offset;
    logic [31:0]         word_off;
    logic                hit;
    logic [AXI_AW-1:0]   axi_addr;

    // Unsigned wrap makes addresses below the base land far above the window.
    assign offset   = obi_addr_i - ADDR_BASE;
    assign hit      = offset < WINDOW_SIZE;
    assign word_off = offset & 32'hFFFF_FFFC;

    generate
        if (AXI_AW == 32) begin : g_aw_eq
            assign axi_addr = word_off;
        end else if (AXI_AW > 32) begin : g_aw_wide
            assign axi_addr = {{(AXI_AW-32){1'b0}}, word_off};
        end else begin : g_aw_narrow
            assign axi_addr = word_off[AXI_AW-1:0];
        end
    endgenerate

    assign obi_gnt_o    = obi_req_i && (state_q == IDLE) && rst_n;
    assign obi_rvalid_o = (state_q == RESP);
    assign obi_rdata_o  = rdata_q;
    assign obi_err_o    = err_q;
    assign m_awvalid_o  = aw_pend_q;
    assign m_wvalid_o   = w_pend_q;
    assign m_awaddr_o   = addr_q;
    assign m_araddr_o   = addr_q;
    assign m_wdata_o    = wdata_q;
    assign m_wstrb_o    = wstrb_q;
    assign m_bready_o   = (state_q == WR_B);
    assign m_arvalid_o  = (state_q == RD_AR);
    assign m_rready_o   = (state_q == RD_R);

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (obi_gnt_o) begin
                    wdata_d = obi_wdata_i;
                    wstrb_d = obi_be_i;
                    rdata_d = '0;
                    err_d   = !hit;
                    if (!hit) begin
                        state_d = RESP;
                    end else begin
                        addr_d = axi_addr;
                        if (obi_we_i) begin
                            state_d   = WR;
                            aw_pend_d = 1'b1;
                            w_pend_d  = 1'b1;
                        end else begin
                            state_d = RD_AR;
                        end
                    end
                end
            end
            WR: begin
                // AW and W retire independently; leave once both have handshaken.
                aw_pend_d = aw_pend_q && !m_awready_i;
                w_pend_d  = w_pend_q && !m_wready_i;
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = WR_B;
                end
            end
            WR_B: begin
                if (m_bvalid_i) begin
                    err_d   = (m_bresp_i != 2'b00);
                    state_d = RESP;
                end
            end
            RD_AR: begin
                if (m_arready_i) begin
                    state_d = RD_R;
                end
            end
            RD_R: begin
                if (m_rvalid_i) begin
                    rdata_d = m_rdata_i;
                    err_d   = (m_rresp_i != 2'b00);
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
